// File: rtl/wb_unit_pkg.sv
// Shared writeback types: register index, data word, FIFO entry.
// Consumed by wb_fifo and wb_unit.
package cpuDefine;

  typedef logic [4:0]  Gr;
  typedef logic [31:0] DType;

  localparam int rfNum       = 32;
  localparam int wbFifoDepth = 4;
  localparam int wbPtrW      = $clog2(wbFifoDepth);

  typedef struct packed {
    Gr    rd;
    DType data;
  } WbEntry;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO queuing long-latency results ahead of the register-file
// write port. Pointers wrap naturally at wbFifoDepth.
module wb_fifo
  import cpuDefine::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  WbEntry push_entry,
  input  logic   pop,
  output WbEntry head,
  output logic   full,
  output logic   empty
);

  logic [wbPtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [wbPtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [wbPtrW:0]   cnt_q, cnt_d;
  WbEntry            mem_q [wbFifoDepth];

  logic do_push;
  logic do_pop;

  assign full    = (cnt_q == (wbPtrW+1)'(wbFifoDepth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + wbPtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + wbPtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (wbPtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (wbPtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback arbiter: ALU results win the port, queued mem results drain
// otherwise; tracks pending long-latency writes. WB_FORWARD_EN adds a lookup.
module wb_unit
  import cpuDefine::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  Gr                issue_rd,
  input  logic             alu_valid,
  input  Gr                alu_rd,
  input  DType             alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  Gr                mem_rd,
  input  DType             mem_data,
  output logic             regWriteEn,
  output Gr                rd_out,
  output DType             regWriteData,
`ifdef WB_FORWARD_EN
  input  Gr                lookup_rd,
  output logic             fwd_hit,
  output DType             fwd_data,
`endif
  output logic [rfNum-1:0] busy
);

  WbEntry push_entry;
  WbEntry head;
  logic   full;
  logic   empty;
  logic   pop;
  logic   push;

  logic             we_q, we_d;
  Gr                rd_q, rd_d;
  DType             data_q, data_d;
  logic [rfNum-1:0] busy_q, busy_d;

  // Held low during reset even though the empty FIFO is not full.
  assign mem_ready  = !full && !reset;
  assign push       = mem_valid && mem_ready;
  assign push_entry = '{rd: mem_rd, data: mem_data};

  wb_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    pop    = 1'b0;
    if (alu_valid) begin
      we_d   = (alu_rd != '0);
      rd_d   = alu_rd;
      data_d = alu_data;
    end else if (!empty) begin
      pop    = 1'b1;
      we_d   = (head.rd != '0);
      rd_d   = head.rd;
      data_d = head.data;
    end
  end

  // Clear before set so an issue on the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop && head.rd != '0) begin
      busy_d[head.rd] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign regWriteEn   = we_q;
  assign rd_out       = rd_q;
  assign regWriteData = data_q;
  assign busy         = busy_q;

`ifdef WB_FORWARD_EN
  assign fwd_hit  = we_q && (rd_q == lookup_rd) && (lookup_rd != '0);
  assign fwd_data = data_q;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit; mem results are tracked in a
// scoreboard queue and compared as they reach the write port.
module tb_wb_unit;
  import cpuDefine::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  Gr                issue_rd;
  logic             alu_valid;
  Gr                alu_rd;
  DType             alu_data;
  logic             mem_valid;
  logic             mem_ready;
  Gr                mem_rd;
  DType             mem_data;
  logic             regWriteEn;
  Gr                rd_out;
  DType             regWriteData;
  logic [rfNum-1:0] busy;
`ifdef WB_FORWARD_EN
  Gr                lookup_rd;
  logic             fwd_hit;
  DType             fwd_data;
`endif

  int checks   = 0;
  int failures = 0;
  WbEntry exp_q[$];

  always #5 clk = ~clk;

  wb_unit dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .regWriteEn   (regWriteEn),
    .rd_out       (rd_out),
    .regWriteData (regWriteData),
`ifdef WB_FORWARD_EN
    .lookup_rd    (lookup_rd),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
`endif
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    mem_valid   = 1'b0;
    mem_rd      = '0;
    mem_data    = '0;
`ifdef WB_FORWARD_EN
    lookup_rd   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (regWriteEn !== 1'b0 || rd_out !== '0 || regWriteData !== '0) begin
      failures++;
      $display("FAIL reset_wport: got we=%b rd=%0d d=%h required 0/0/0",
               regWriteEn, rd_out, regWriteData);
    end
    checks++;
    if (busy !== '0) begin
      failures++;
      $display("FAIL reset_busy: got %h required 0", busy);
    end
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b required 0", mem_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready: got %b required 1", mem_ready);
    end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h1234;
    tick();
    alu_valid = 1'b0;
    checks++;
    if (regWriteEn !== 1'b1 || rd_out !== 5'd5 || regWriteData !== 32'h1234) begin
      failures++;
      $display("FAIL alu_write: got we=%b rd=%0d d=%h required 1/5/1234",
               regWriteEn, rd_out, regWriteData);
    end
`ifdef WB_FORWARD_EN
    lookup_rd = 5'd5;
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h1234) begin
      failures++;
      $display("FAIL fwd_hit: got hit=%b d=%h required 1/1234",
               fwd_hit, fwd_data);
    end
    lookup_rd = 5'd0;
    #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      failures++;
      $display("FAIL fwd_rd0: got hit=%b required 0", fwd_hit);
    end
`endif
    tick();
    checks++;
    if (regWriteEn !== 1'b0) begin
      failures++;
      $display("FAIL alu_idle: got we=%b required 0", regWriteEn);
    end
  endtask

  task automatic test_mem();
    WbEntry e;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy[7] !== 1'b1) begin
      failures++;
      $display("FAIL busy_set: got %b required 1", busy[7]);
    end
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'hAA;
    exp_q.push_back('{rd: 5'd7, data: 32'hAA});
    tick();
    mem_valid = 1'b0;
    checks++;
    if (regWriteEn !== 1'b0 || busy[7] !== 1'b1) begin
      failures++;
      $display("FAIL mem_latency: got we=%b busy7=%b required 0/1",
               regWriteEn, busy[7]);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (regWriteEn !== 1'b1 || rd_out !== e.rd || regWriteData !== e.data) begin
      failures++;
      $display("FAIL mem_write: got we=%b rd=%0d d=%h required 1/%0d/%h",
               regWriteEn, rd_out, regWriteData, e.rd, e.data);
    end
    checks++;
    if (busy[7] !== 1'b0) begin
      failures++;
      $display("FAIL busy_clear: got %b required 0", busy[7]);
    end
  endtask

  task automatic test_full();
    WbEntry e;
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    for (int i = 0; i < 4; i++) begin
      alu_data  = 32'h300 + i;
      mem_valid = 1'b1;
      mem_rd    = Gr'(12 + i);
      mem_data  = 32'hB0 + i;
      exp_q.push_back('{rd: Gr'(12 + i), data: 32'hB0 + i});
      tick();
      checks++;
      if (regWriteEn !== 1'b1 || rd_out !== 5'd3 ||
          regWriteData !== 32'h300 + i) begin
        failures++;
        $display("FAIL alu_prio[%0d]: got we=%b rd=%0d d=%h required 1/3/%h",
                 i, regWriteEn, rd_out, regWriteData, 32'h300 + i);
      end
    end
    mem_rd   = 5'd16;
    mem_data = 32'hDEAD;
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: got %b required 0", mem_ready);
    end
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (regWriteEn !== 1'b1 || rd_out !== e.rd || regWriteData !== e.data) begin
        failures++;
        $display("FAIL drain[%0d]: got we=%b rd=%0d d=%h required 1/%0d/%h",
                 i, regWriteEn, rd_out, regWriteData, e.rd, e.data);
      end
      if (i == 0) begin
        checks++;
        if (mem_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_pop: got %b required 1", mem_ready);
        end
      end
    end
    tick();
    checks++;
    if (regWriteEn !== 1'b0) begin
      failures++;
      $display("FAIL drain_end: got we=%b required 0", regWriteEn);
    end
  endtask

  task automatic test_rd0();
    int seen = 0;
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    tick();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd0;
    alu_data    = 32'h77;
    mem_valid   = 1'b1;
    mem_rd      = 5'd0;
    mem_data    = 32'h55;
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    if (regWriteEn !== 1'b0) seen++;
    repeat (2) begin
      tick();
      if (regWriteEn !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rd0_write: got %0d enabled cycles required 0", seen);
    end
    checks++;
    if (busy !== 32'h10 || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd0_state: got busy=%h ready=%b required 10/1",
               busy, mem_ready);
    end
  endtask

  task automatic test_back_to_back();
    WbEntry e;
    int writes = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        mem_valid = 1'b1;
        mem_rd    = Gr'(17 + i);
        mem_data  = $urandom;
        exp_q.push_back('{rd: mem_rd, data: mem_data});
      end else begin
        mem_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 6) begin
        checks++;
        if (regWriteEn !== 1'b1) begin
          failures++;
          $display("FAIL b2b_stream[%0d]: got we=%b required 1", i, regWriteEn);
        end
      end
      if (regWriteEn === 1'b1) begin
        writes++;
        e = exp_q.pop_front();
        checks++;
        if (rd_out !== e.rd || regWriteData !== e.data) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got rd=%0d d=%h required %0d/%h",
                   i, rd_out, regWriteData, e.rd, e.data);
        end
      end
    end
    checks++;
    if (writes != 6) begin
      failures++;
      $display("FAIL b2b_count: got %0d required 6", writes);
    end
  endtask

  task automatic test_set_wins_and_reset();
    int seen = 0;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    mem_valid   = 1'b1;
    mem_rd      = 5'd9;
    mem_data    = 32'h99;
    tick();
    mem_valid   = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (regWriteEn !== 1'b1 || rd_out !== 5'd9 || busy[9] !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: got we=%b rd=%0d busy9=%b required 1/9/1",
               regWriteEn, rd_out, busy[9]);
    end
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    for (int i = 0; i < 3; i++) begin
      mem_valid   = 1'b1;
      mem_rd      = Gr'(20 + i);
      mem_data    = 32'hC0 + i;
      issue_valid = (i == 0);
      issue_rd    = 5'd20;
      tick();
    end
    issue_valid = 1'b0;
    mem_valid   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== '0 || regWriteEn !== 1'b0 || mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got busy=%h we=%b ready=%b required 0/0/0",
               busy, regWriteEn, mem_ready);
    end
    alu_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: got %b required 1", mem_ready);
    end
    repeat (5) begin
      tick();
      if (regWriteEn !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || busy !== '0) begin
      failures++;
      $display("FAIL flushed: got %0d writes busy=%h required 0/0", seen, busy);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_full();
    test_rd0();
    test_back_to_back();
    test_set_wins_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
